// File: rtl/lane_pg_pkg.sv
// Shared types and helpers for the lane power-gating controller.
package lane_pg_pkg;

    typedef enum logic [1:0] {
        PG_ON   = 2'd0,
        PG_OFF  = 2'd1,
        PG_WAKE = 2'd2
    } pg_state_e;

    // Counter width large enough to hold max(idle, wake) - 1 without wrapping.
    function automatic int pg_cnt_width(input int idle_cycles, input int wake_cycles);
        int m;
        m = (idle_cycles > wake_cycles) ? idle_cycles : wake_cycles;
        return (m > 1) ? $clog2(m + 1) : 1;
    endfunction

endpackage

// File: rtl/lane_pg_wake_arbiter.sv
// Round-robin wake arbiter: at most one grant per cycle; search starts at the pointer.
module lane_pg_wake_arbiter #(
    parameter int NrUnits = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NrUnits-1:0] req_i,
    output logic [NrUnits-1:0] gnt_o
);
    localparam int PtrW = (NrUnits > 1) ? $clog2(NrUnits) : 1;

    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [PtrW-1:0] idx;
    logic [PtrW:0]   sum;
    logic [PtrW:0]   nxt;
    logic            found;

    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = '0;
        sum   = '0;
        nxt   = '0;
        for (int i = 0; i < NrUnits; i++) begin
            sum = {1'b0, ptr_q} + (PtrW+1)'(i);
            if (sum >= (PtrW+1)'(NrUnits)) sum = sum - (PtrW+1)'(NrUnits);
            idx = PtrW'(sum);
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                nxt        = sum + (PtrW+1)'(1);
                if (nxt >= (PtrW+1)'(NrUnits)) nxt = '0;
                ptr_d      = PtrW'(nxt);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/lane_pg_ctrl.sv
// Per-lane power-gating controller: idle timeout gates units, serialised wake-up restores them.
module lane_pg_ctrl
    import lane_pg_pkg::*;
#(
    parameter int NrUnits    = 4,
    parameter int IdleCycles = 16,
    parameter int WakeCycles = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               gating_en_i,
    input  logic [NrUnits-1:0] req_i,
    input  logic [NrUnits-1:0] busy_i,
    output logic [NrUnits-1:0] en_o,
    output logic [NrUnits-1:0] ready_o,
    output logic [NrUnits-1:0] gated_o
);
    localparam int CntWidth = pg_cnt_width(IdleCycles, WakeCycles);

    logic [NrUnits-1:0] wake_req;
    logic [NrUnits-1:0] gnt;

    lane_pg_wake_arbiter #(.NrUnits(NrUnits)) i_arb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i (wake_req),
        .gnt_o (gnt)
    );

    for (genvar u = 0; u < NrUnits; u++) begin : g_unit
        pg_state_e           state_q;
        logic [CntWidth-1:0] cnt_q;
        logic                en_q, ready_q, gated_q;
        logic                idle;

        assign idle        = !req_i[u] && !busy_i[u];
        assign wake_req[u] = (state_q == PG_OFF) && (req_i[u] || !gating_en_i);
        assign en_o[u]     = en_q;
        assign ready_o[u]  = ready_q;
        assign gated_o[u]  = gated_q;

        // Outputs are registered alongside the state so they always match it.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state_q <= PG_ON;
                cnt_q   <= '0;
                en_q    <= 1'b1;
                ready_q <= 1'b1;
                gated_q <= 1'b0;
            end else begin
                case (state_q)
                    PG_ON: begin
                        if (!idle || !gating_en_i) begin
                            cnt_q <= '0;
                        end else if (cnt_q == CntWidth'(IdleCycles - 1)) begin
                            state_q <= PG_OFF;
                            cnt_q   <= '0;
                            en_q    <= 1'b0;
                            ready_q <= 1'b0;
                            gated_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    PG_OFF: begin
                        if (gnt[u]) begin
                            state_q <= PG_WAKE;
                            cnt_q   <= '0;
                            en_q    <= 1'b1;
                            ready_q <= 1'b0;
                            gated_q <= 1'b0;
                        end
                    end
                    PG_WAKE: begin
                        if (cnt_q == CntWidth'(WakeCycles - 1)) begin
                            state_q <= PG_ON;
                            cnt_q   <= '0;
                            en_q    <= 1'b1;
                            ready_q <= 1'b1;
                            gated_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= PG_ON;
                        cnt_q   <= '0;
                        en_q    <= 1'b1;
                        ready_q <= 1'b1;
                        gated_q <= 1'b0;
                    end
                endcase
            end
        end

        a_no_busy_off: assert property (@(posedge clk_i) disable iff (rst_i)
            !(state_q == PG_OFF && busy_i[u]));
    end

endmodule

// File: tb/tb_lane_pg_ctrl.sv
// Directed and randomized checks of lane_pg_ctrl against a cycle-level behavioural model.
module tb_lane_pg_ctrl;
    localparam int NU   = 4;
    localparam int IDLE = 16;
    localparam int WAKE = 2;
    localparam int M_ON = 0, M_OFF = 1, M_WAKE = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          gen;
    logic [NU-1:0] req, busy;
    logic [NU-1:0] en, ready, gated;

    int ncmp = 0, nerr = 0;
    int mst[NU], run[NU], age[NU];
    int ptr;

    lane_pg_ctrl #(.NrUnits(NU), .IdleCycles(IDLE), .WakeCycles(WAKE)) dut (
        .clk_i(clk), .rst_i(rst), .gating_en_i(gen),
        .req_i(req), .busy_i(busy),
        .en_o(en), .ready_o(ready), .gated_o(gated)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [NU-1:0] obs, input logic [NU-1:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < NU; u++) begin
            mst[u] = M_ON; run[u] = 0; age[u] = 0;
        end
        ptr = 0;
    endtask

    // One clock edge of the rules: consecutive-idle run length, wake age since grant, RR grant.
    task automatic model_edge();
        int g;
        g = -1;
        for (int i = 0; i < NU; i++) begin
            int k;
            k = (ptr + i) % NU;
            if (g < 0 && mst[k] == M_OFF && (req[k] || !gen)) g = k;
        end
        if (g >= 0) ptr = (g + 1) % NU;
        for (int u = 0; u < NU; u++) begin
            case (mst[u])
                M_ON: begin
                    if (gen && !req[u] && !busy[u]) begin
                        run[u]++;
                        if (run[u] == IDLE) begin mst[u] = M_OFF; run[u] = 0; end
                    end else run[u] = 0;
                end
                M_OFF: if (g == u) begin mst[u] = M_WAKE; age[u] = 0; end
                default: begin
                    age[u]++;
                    if (age[u] == WAKE) begin mst[u] = M_ON; run[u] = 0; end
                end
            endcase
        end
    endtask

    task automatic model_check();
        logic [NU-1:0] e, r, gt;
        for (int u = 0; u < NU; u++) begin
            e[u]  = (mst[u] != M_OFF);
            r[u]  = (mst[u] == M_ON);
            gt[u] = (mst[u] == M_OFF);
        end
        check("model_en", en, e);
        check("model_ready", ready, r);
        check("model_gated", gated, gt);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        model_check();
    endtask

    initial begin
        rst = 1'b1; gen = 1'b1; req = '0; busy = '0;
        model_reset();
        #12;
        check("reset_en", en, 4'b1111);
        check("reset_ready", ready, 4'b1111);
        check("reset_gated", gated, 4'b0000);
        @(negedge clk);
        rst = 1'b0;

        // Idle timeout: gated exactly IDLE edges after release.
        repeat (IDLE - 1) step();
        check("t1_not_yet", gated, 4'b0000);
        step();
        check("t1_gated", gated, 4'b1111);
        check("t1_en", en, 4'b0000);
        check("t1_ready", ready, 4'b0000);

        // Contended wake from pointer 0.
        req = 4'b1111;
        step(); check("t4_en0", en, 4'b0001);
        step(); check("t4_en1", en, 4'b0011);
        step(); check("t4_en2", en, 4'b0111); check("t4_rdy0", ready, 4'b0001);
        step(); check("t4_en3", en, 4'b1111);
        step(); step(); check("t4_rdy_all", ready, 4'b1111);

        // Late activity on unit 1 in its terminal idle cycle.
        req = 4'b0000;
        repeat (IDLE - 1) step();
        req = 4'b0010;
        step();
        check("t2_unit1_on", gated & 4'b0010, 4'b0000);
        repeat (15) step();
        check("t2_unit1_still_on", gated & 4'b0010, 4'b0000);
        req = 4'b0000;
        repeat (IDLE + 2) step();
        check("t2_all_off", gated, 4'b1111);

        // Single wake of unit 2.
        req = 4'b0100;
        step();
        req = 4'b0000;
        check("t3_en2", en & 4'b0100, 4'b0100);
        check("t3_gated2", gated & 4'b0100, 4'b0000);
        step(); check("t3_not_ready", ready & 4'b0100, 4'b0000);
        step(); check("t3_ready", ready & 4'b0100, 4'b0100);
        repeat (IDLE + 2) step();
        check("t3_all_off", gated, 4'b1111);

        // Global disable: everyone wakes and stays on.
        gen = 1'b0;
        repeat (NU + WAKE) step();
        check("t5_all_ready", ready, 4'b1111);
        repeat (100) begin
            req  = NU'($urandom_range(0, 15)) & NU'($urandom_range(0, 15));
            busy = NU'($urandom_range(0, 15)) & NU'($urandom_range(0, 15));
            step();
        end
        check("t5_no_regate", gated, 4'b0000);
        gen = 1'b1; req = '0; busy = '0;
        repeat (IDLE + 2) step();
        check("t6_all_off", gated, 4'b1111);

        // Async reset mid-wake of unit 3, between clock edges.
        req = 4'b1000;
        step();
        req = 4'b0000;
        check("t6_wake3", en, 4'b1000);
        #2 rst = 1'b1;
        #1;
        check("t6_async_en", en, 4'b1111);
        check("t6_async_ready", ready, 4'b1111);
        check("t6_async_gated", gated, 4'b0000);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (IDLE - 1) step();
        check("t6_not_yet", gated, 4'b0000);
        step();
        check("t6_regated", gated, 4'b1111);

        // Randomized traffic with sparse activity so gating and wake both occur.
        repeat (600) begin
            for (int u = 0; u < NU; u++) begin
                req[u]  = ($urandom_range(0, 24) == 0);
                busy[u] = (mst[u] != M_OFF) && ($urandom_range(0, 24) == 0);
            end
            if ($urandom_range(0, 99) == 0) gen = ~gen;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
